// File: rtl/snake_step_sequencer_pkg.sv
// Shared constants for the snake step sequencer: grid size defaults, direction and FSM encodings.
// The self-collision scan is compiled in only when SNAKE_SELF_COLLIDE_EN is defined.
package snake_step_sequencer_pkg;

  localparam int DEF_GRID_WIDTH       = 16;
  localparam int DEF_GRID_HEIGHT      = 12;
  localparam int DEF_NUM_SNAKE_PIECES = 8;
  localparam int DEF_FRAMES_PER_STEP  = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DEAD   = 3'd4
  } state_e;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic is_reverse(input dir_e a, input dir_e b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: moves the head one cell along the heading and flags wall cells.
module snake_next_head
  import snake_step_sequencer_pkg::*;
#(
  parameter int GRID_WIDTH  = DEF_GRID_WIDTH,
  parameter int GRID_HEIGHT = DEF_GRID_HEIGHT,
  parameter int YB          = $clog2(GRID_HEIGHT),
  parameter int XB          = $clog2(GRID_WIDTH)
) (
  input  dir_e          dir,
  input  logic [YB-1:0] head_y,
  input  logic [XB-1:0] head_x,
  output logic [YB-1:0] next_y,
  output logic [XB-1:0] next_x,
  output logic          wall_hit
);

  localparam logic [YB:0] ONE_Y = (YB+1)'(1);
  localparam logic [XB:0] ONE_X = (XB+1)'(1);
  localparam logic [YB:0] MAX_Y = (YB+1)'(GRID_HEIGHT - 1);
  localparam logic [XB:0] MAX_X = (XB+1)'(GRID_WIDTH - 1);

  logic [YB:0] wide_y;
  logic [XB:0] wide_x;

  // One extra bit so that stepping off either edge is seen before truncation.
  always_comb begin
    wide_y = {1'b0, head_y};
    wide_x = {1'b0, head_x};
    unique case (dir)
      DIR_UP:    wide_y = wide_y - ONE_Y;
      DIR_RIGHT: wide_x = wide_x + ONE_X;
      DIR_DOWN:  wide_y = wide_y + ONE_Y;
      DIR_LEFT:  wide_x = wide_x - ONE_X;
    endcase
    wall_hit = (wide_y == '0) || (wide_y >= MAX_Y) || (wide_x == '0) || (wide_x >= MAX_X);
    next_y   = wide_y[YB-1:0];
    next_x   = wide_x[XB-1:0];
  end

endmodule

// File: rtl/snake_step_sequencer.sv
// Snake game-state sequencer: steps the snake during vertical blanking every FRAMES_PER_STEP frames.
// Define SNAKE_SELF_COLLIDE_EN to add the self-collision CHECK scan between CALC and COMMIT.
module snake_step_sequencer
  import snake_step_sequencer_pkg::*;
#(
  parameter int GRID_WIDTH      = DEF_GRID_WIDTH,
  parameter int GRID_HEIGHT     = DEF_GRID_HEIGHT,
  parameter int NUM_PIECES      = DEF_NUM_SNAKE_PIECES,
  parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
  localparam int YB = $clog2(GRID_HEIGHT),
  localparam int XB = $clog2(GRID_WIDTH),
  localparam int LW = $clog2(NUM_PIECES) + 1
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     FrameStart,
  input  logic                     DirValid,
  input  logic [1:0]               Dir,
  input  logic                     FoodLoad,
  input  logic [YB-1:0]            FoodYIn,
  input  logic [XB-1:0]            FoodXIn,
  output logic [0:YB*NUM_PIECES-1] packSnakeY,
  output logic [0:XB*NUM_PIECES-1] packSnakeX,
  output logic [YB-1:0]            FoodY,
  output logic [XB-1:0]            FoodX,
  output logic [LW-1:0]            Length,
  output logic                     EatPulse,
  output logic                     GameOver,
  output logic                     Busy
);

  localparam int FCW = $clog2(FRAMES_PER_STEP) + 1;
  localparam int SW  = $clog2(NUM_PIECES);

  state_e          state_q, state_d;
  logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
  dir_e            heading_q, heading_d;
  dir_e            dir_pend_q, dir_pend_d;
  logic [YB-1:0]   y_q [NUM_PIECES];
  logic [YB-1:0]   y_d [NUM_PIECES];
  logic [XB-1:0]   x_q [NUM_PIECES];
  logic [XB-1:0]   x_d [NUM_PIECES];
  logic [YB-1:0]   food_y_q, food_y_d;
  logic [XB-1:0]   food_x_q, food_x_d;
  logic [LW-1:0]   length_q, length_d;
  logic            eat_q, eat_d;
  logic            game_over_q, game_over_d;
  logic            busy_q, busy_d;
  logic [YB-1:0]   next_y_q, next_y_d;
  logic [XB-1:0]   next_x_q, next_x_d;
  logic            hit_q, hit_d;
`ifdef SNAKE_SELF_COLLIDE_EN
  logic [SW-1:0]   scan_q, scan_d;
`endif

  logic [YB-1:0]   nh_y;
  logic [XB-1:0]   nh_x;
  logic            nh_hit;
  logic            eat_hit;
  logic [LW-1:0]   len_new;

  snake_next_head #(
    .GRID_WIDTH (GRID_WIDTH),
    .GRID_HEIGHT(GRID_HEIGHT),
    .YB         (YB),
    .XB         (XB)
  ) u_next_head (
    .dir     (dir_pend_q),
    .head_y  (y_q[0]),
    .head_x  (x_q[0]),
    .next_y  (nh_y),
    .next_x  (nh_x),
    .wall_hit(nh_hit)
  );

  // DirValid/Dir and FoodLoad/FoodYIn/FoodXIn are valid-only requests with no ready:
  // a request is consumed (or dropped) in the very cycle its valid is high.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    heading_d   = heading_q;
    dir_pend_d  = dir_pend_q;
    y_d         = y_q;
    x_d         = x_q;
    food_y_d    = food_y_q;
    food_x_d    = food_x_q;
    length_d    = length_q;
    eat_d       = 1'b0;
    game_over_d = game_over_q;
    next_y_d    = next_y_q;
    next_x_d    = next_x_q;
    hit_d       = hit_q;
`ifdef SNAKE_SELF_COLLIDE_EN
    scan_d      = scan_q;
`endif
    eat_hit     = 1'b0;
    len_new     = length_q;

    if (DirValid && state_q != ST_DEAD && !is_reverse(dir_e'(Dir), heading_q))
      dir_pend_d = dir_e'(Dir);
    if (FoodLoad && state_q inside {ST_IDLE, ST_CALC, ST_CHECK}) begin
      food_y_d = FoodYIn;
      food_x_d = FoodXIn;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (FrameStart) begin
          if (frame_cnt_q == FCW'(FRAMES_PER_STEP - 1)) begin
            frame_cnt_d = '0;
            state_d     = ST_CALC;
          end else begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end
      end
      ST_CALC: begin
        heading_d = dir_pend_q;
        next_y_d  = nh_y;
        next_x_d  = nh_x;
        hit_d     = nh_hit;
`ifdef SNAKE_SELF_COLLIDE_EN
        scan_d    = '0;
        state_d   = ST_CHECK;
`else
        state_d   = ST_COMMIT;
`endif
      end
      ST_CHECK: begin
`ifdef SNAKE_SELF_COLLIDE_EN
        // The tail slot is skipped: it moves away in the same step.
        if ((int'(scan_q) + 2 <= int'(length_q)) &&
            (y_q[scan_q] == next_y_q) && (x_q[scan_q] == next_x_q))
          hit_d = 1'b1;
        if (scan_q == SW'(NUM_PIECES - 2)) state_d = ST_COMMIT;
        else                               scan_d  = scan_q + SW'(1);
`else
        state_d = ST_COMMIT;
`endif
      end
      ST_COMMIT: begin
        if (hit_q) begin
          game_over_d = 1'b1;
          state_d     = ST_DEAD;
        end else begin
          eat_hit = (next_y_q == food_y_q) && (next_x_q == food_x_q);
          if (eat_hit && length_q < LW'(NUM_PIECES)) len_new = length_q + LW'(1);
          y_d[0] = next_y_q;
          x_d[0] = next_x_q;
          for (int i = 1; i < NUM_PIECES; i++) begin
            y_d[i] = y_q[i-1];
            x_d[i] = x_q[i-1];
          end
          for (int i = 0; i < NUM_PIECES; i++) begin
            if (LW'(i) >= len_new) begin
              y_d[i] = '0;
              x_d[i] = '0;
            end
          end
          length_d = len_new;
          if (eat_hit) begin
            eat_d    = 1'b1;
            food_y_d = '0;
            food_x_d = '0;
          end
          state_d = ST_IDLE;
        end
      end
      ST_DEAD: state_d = ST_DEAD;
      default: state_d = ST_IDLE;
    endcase

    busy_d = state_d inside {ST_CALC, ST_CHECK, ST_COMMIT};
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      heading_q   <= DIR_RIGHT;
      dir_pend_q  <= DIR_RIGHT;
      for (int i = 0; i < NUM_PIECES; i++) begin
        y_q[i] <= (i < 3) ? YB'(GRID_HEIGHT / 2) : '0;
        x_q[i] <= (i < 3) ? XB'(GRID_WIDTH / 2 - i) : '0;
      end
      food_y_q    <= YB'(2);
      food_x_q    <= XB'(2);
      length_q    <= LW'(3);
      eat_q       <= 1'b0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
      next_y_q    <= '0;
      next_x_q    <= '0;
      hit_q       <= 1'b0;
`ifdef SNAKE_SELF_COLLIDE_EN
      scan_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      heading_q   <= heading_d;
      dir_pend_q  <= dir_pend_d;
      y_q         <= y_d;
      x_q         <= x_d;
      food_y_q    <= food_y_d;
      food_x_q    <= food_x_d;
      length_q    <= length_d;
      eat_q       <= eat_d;
      game_over_q <= game_over_d;
      busy_q      <= busy_d;
      next_y_q    <= next_y_d;
      next_x_q    <= next_x_d;
      hit_q       <= hit_d;
`ifdef SNAKE_SELF_COLLIDE_EN
      scan_q      <= scan_d;
`endif
    end
  end

  for (genvar gi = 0; gi < NUM_PIECES; gi++) begin : g_pack
    for (genvar gk = 0; gk < YB; gk++) begin : g_y
      assign packSnakeY[gi*YB + gk] = y_q[gi][gk];
    end
    for (genvar gk = 0; gk < XB; gk++) begin : g_x
      assign packSnakeX[gi*XB + gk] = x_q[gi][gk];
    end
  end

  assign FoodY    = food_y_q;
  assign FoodX    = food_x_q;
  assign Length   = length_q;
  assign EatPulse = eat_q;
  assign GameOver = game_over_q;
  assign Busy     = busy_q;

endmodule
